// File: rtl/xm23_pkg.sv
// Shared XM23 definitions: memory-controller state encoding, control-register
// field encodings and bit positions, and a small alignment helper.
package xm23_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic SZ_WORD  = 1'b0;
    localparam logic SZ_BYTE  = 1'b1;

    // Bit positions inside the CPU control register, so the CPU top can wire
    // ctrl_reg[CR_EN] etc. straight onto req/rw/wb.
    localparam int CR_EN = 0;
    localparam int CR_RW = 1;
    localparam int CR_WB = 2;

    // A word access must start on an even byte address.
    function automatic logic is_misaligned(input logic wb, input logic addr_lsb);
        return (wb == SZ_WORD) && addr_lsb;
    endfunction

endpackage

// File: rtl/xm23_mem_ctrl_if.sv
// Bus between the XM23 control unit / byte RAM and the memory controller.
// The controller takes the slave view; the CPU side and RAM take the master view.
interface xm23_mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              rw;
    logic              wb;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;

    modport master (
        output req, rw, wb, mar, wdata, ram_rdata,
        input  rdata, busy, done, err, ram_addr, ram_wdata, ram_we, ram_re
    );

    modport slave (
        input  req, rw, wb, mar, wdata, ram_rdata,
        output rdata, busy, done, err, ram_addr, ram_wdata, ram_we, ram_re
    );

endinterface

// File: rtl/xm23_mem_ctrl.sv
// XM23 memory bus controller: turns one CR/MAR/MDR request into one or two
// byte cycles on a synchronous byte-wide RAM and returns read data for the MDR.
module xm23_mem_ctrl
    import xm23_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    xm23_mem_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic              rw_q;
    logic              wb_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] addr_c;
    logic [7:0]        wbyte_c;
    logic              we_c;
    logic              re_c;
    logic              done_c;
    logic              err_c;

    // NOTE: all registered state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rw_q    <= RW_READ;
            wb_q    <= SZ_WORD;
            mar_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && bus.req) begin
                rw_q    <= bus.rw;
                wb_q    <= bus.wb;
                mar_q   <= bus.mar;
                wdata_q <= bus.wdata;
            end

            // RAM data for the byte addressed last cycle arrives this cycle.
            if (rw_q == RW_READ) begin
                case (state_q)
                    ST_HI:  rdata_q[7:0] <= bus.ram_rdata;
                    ST_FIN: begin
                        if (wb_q == SZ_WORD)
                            rdata_q[DATA_W-1:8] <= bus.ram_rdata;
                        else
                            rdata_q <= DATA_W'(bus.ram_rdata);
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        addr_c  = '0;
        wbyte_c = '0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req)
                    state_d = is_misaligned(bus.wb, bus.mar[0]) ? ST_ERR : ST_LO;
            end
            ST_LO: begin
                addr_c = mar_q;
                if (rw_q == RW_WRITE) begin
                    we_c    = 1'b1;
                    wbyte_c = wdata_q[7:0];
                end else begin
                    re_c    = 1'b1;
                end
                state_d = (wb_q == SZ_WORD) ? ST_HI : ST_FIN;
            end
            ST_HI: begin
                addr_c = mar_q + ADDR_W'(1);
                if (rw_q == RW_WRITE) begin
                    we_c    = 1'b1;
                    wbyte_c = wdata_q[DATA_W-1:8];
                end else begin
                    re_c    = 1'b1;
                end
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done_c  = 1'b1;
                err_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_c;
    assign bus.err       = err_c;
    assign bus.ram_addr  = addr_c;
    assign bus.ram_wdata = wbyte_c;
    // Strobes are masked during reset so an aborted word write cannot
    // complete its pending byte on the same edge that resets the FSM.
    assign bus.ram_we    = we_c & ~rst;
    assign bus.ram_re    = re_c & ~rst;

endmodule
